// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI configuration target.
//   - register address map (reg 0x00..0x04)
//   - frame geometry: 16 bits = {R/W, addr[6:0], data[7:0]}
//   - FSM state encoding
package spi_pkg;
  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int NUM_REGS   = 5;
  localparam int CNT_W      = 5;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: STAGES-deep synchronizer for one async pin, plus a history
// flop that turns level changes into single-cycle rise/fall pulses.
//   clk, rst_n  : system clock, async active-low reset
//   d_i         : raw asynchronous input
//   level_o     : synchronized level
//   rise_o/fall_o : one-cycle pulses on synchronized 0->1 / 1->0
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;
endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 write-only target programming the PWM config regs.
//   clk, rst_n        : system clock, async active-low reset
//   sclk, copi, ncs   : raw SPI pins (async to clk)
//   en_reg_out_7_0    : reg 0x00   en_reg_out_15_8 : reg 0x01
//   en_reg_pwm_7_0    : reg 0x02   en_reg_pwm_15_8 : reg 0x03
//   pwm_duty_cycle    : reg 0x04
// A frame commits only if exactly 16 bits arrived, R/W=1 and addr<=MAX_ADDR.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(FRAME_BITS + 1);

  logic sclk_rise, copi_s, ncs_rise, ncs_fall;
  logic sclk_level_unused, sclk_fall_unused;
  logic copi_rise_unused, copi_fall_unused, ncs_level_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk),
    .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused));

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d_i(copi),
    .level_o(copi_s), .rise_o(copi_rise_unused), .fall_o(copi_fall_unused));

  // nCS chain resets low: if nCS is already low at reset release no fall is
  // seen, so a frame in progress is ignored until a fresh falling edge. A high
  // nCS yields a rise pulse instead, which IDLE ignores.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d_i(ncs),
    .level_o(ncs_level_unused), .rise_o(ncs_rise), .fall_o(ncs_fall));

  state_e                             state_q, state_d;
  logic   [FRAME_BITS-1:0]            shift_q, shift_d;
  logic   [CNT_W-1:0]                 cnt_q, cnt_d;
  logic   [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
  logic                               start, shift_en, commit_en, commit_ok;
  frame_t                             frm;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state; an nCS fall during COMMIT goes straight to SHIFT
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ncs_fall) state_d = SHIFT;
      SHIFT:   if (ncs_rise) state_d = COMMIT;
      COMMIT:  state_d = ncs_fall ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; an SCLK rise coincident with the nCS fall is bit 15
  always_comb begin
    start     = ncs_fall && (state_q == IDLE || state_q == COMMIT);
    shift_en  = sclk_rise && (start || (state_q == SHIFT && !ncs_rise));
    commit_en = (state_q == COMMIT);
  end

  assign frm       = frame_t'(shift_q);
  assign commit_ok = commit_en && (cnt_q == CNT_FULL) && frm.wr
                     && (frm.addr <= ADDR_W'(MAX_ADDR));

  always_comb begin
    shift_d = shift_en ? {shift_q[FRAME_BITS-2:0], copi_s} : shift_q;
    cnt_d   = cnt_q;
    if (start)                             cnt_d = shift_en ? CNT_W'(1) : '0;
    else if (shift_en && cnt_q != CNT_OVR) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    regs_d = regs_q;
    if (commit_ok) begin
      case (frm.addr)
        ADDR_EN_OUT_LO: regs_d[0] = frm.data;
        ADDR_EN_OUT_HI: regs_d[1] = frm.data;
        ADDR_EN_PWM_LO: regs_d[2] = frm.data;
        ADDR_EN_PWM_HI: regs_d[3] = frm.data;
        ADDR_DUTY:      regs_d[4] = frm.data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      regs_q  <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: table of whole frames plus hand-written
// sequences for same-cycle edges, tight back-to-back, and reset corners.
module tb_spi_peripheral;
  localparam time HALF = 40ns;  // SCLK half period = 4 clk

  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
  logic [7:0] r0, r1, r2, r3, r4;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  spi_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4));

  typedef struct {
    logic [16:0] frame;
    int          nbits;
    logic [39:0] exp;   // {duty, pwm15_8, pwm7_0, out15_8, out7_0}
  } vec_t;
  vec_t vecs[11];

  task automatic check_all(input string name, input logic [39:0] exp);
    logic [39:0] act;
    string rn[5];
    rn = '{"out7_0", "out15_8", "pwm7_0", "pwm15_8", "duty"};
    act = {r4, r3, r2, r1, r0};
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (act[8*i +: 8] !== exp[8*i +: 8]) begin
        fails++;
        $display("FAIL %s.%s: got %h expected %h", name, rn[i], act[8*i +: 8], exp[8*i +: 8]);
      end
    end
  endtask

  task automatic shift_bits(input logic [16:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sclk = 1'b0; copi = f[i]; #HALF;
      sclk = 1'b1; #HALF;
    end
    sclk = 1'b0;
  endtask

  // nCS rise aligned just after a clk edge; 4 edges later the commit must be visible
  task automatic end_frame();
    #HALF;
    @(posedge clk); #1;
    ncs = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [16:0] f, input int n);
    ncs = 1'b0; #HALF;
    shift_bits(f, n);
    end_frame();
  endtask

  initial begin
    vecs[0]  = '{17'h080F0, 16, 40'h00_00_00_00_F0};
    vecs[1]  = '{17'h08011, 16, 40'h00_00_00_00_11};
    vecs[2]  = '{17'h08122, 16, 40'h00_00_00_22_11};
    vecs[3]  = '{17'h08233, 16, 40'h00_00_33_22_11};
    vecs[4]  = '{17'h08344, 16, 40'h00_44_33_22_11};
    vecs[5]  = '{17'h08480, 16, 40'h80_44_33_22_11};
    vecs[6]  = '{17'h08555, 16, 40'h80_44_33_22_11};  // addr 5
    vecs[7]  = '{17'h00455, 16, 40'h80_44_33_22_11};  // read
    vecs[8]  = '{17'h00008, 16, 40'h80_44_33_22_11};  // read, leaves low nibble 8
    vecs[9]  = '{17'h004AA, 12, 40'h80_44_33_22_11};  // short
    vecs[10] = '{17'h18455, 17, 40'h80_44_33_22_11};  // over-long

    #25 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_all("reset", 40'h0);

    for (int i = 0; i < 11; i++) begin
      send_frame(vecs[i].frame, vecs[i].nbits);
      check_all($sformatf("vec%0d", i), vecs[i].exp);
      gap();
    end

    // nCS fall and first SCLK rise in the same instant
    copi = 1'b1; ncs = 1'b0; sclk = 1'b1; #HALF;
    sclk = 1'b0;
    shift_bits(17'h00133, 15);
    end_frame();
    check_all("same_edge", 40'h80_44_33_33_11);
    gap();

    // nCS high for one clk only: the new fall lands in COMMIT
    ncs = 1'b0; #HALF;
    shift_bits(17'h08301, 16);
    #HALF;
    @(posedge clk); #1; ncs = 1'b1;
    @(posedge clk); #1; ncs = 1'b0;
    #HALF;
    shift_bits(17'h08402, 16);
    end_frame();
    check_all("tight_b2b", 40'h02_01_33_33_11);
    gap();

    // reset mid-frame
    ncs = 1'b0; #HALF;
    shift_bits(17'(16'h8277 >> 6), 10);
    #7 rst_n = 1'b0;
    #20;
    check_all("rst_mid", 40'h0);
    ncs = 1'b1; #HALF;
    rst_n = 1'b1;
    gap();
    send_frame(17'h08277, 16);
    check_all("after_rst", 40'h00_00_77_00_00);
    gap();

    // SCLK toggling with nCS high is ignored
    for (int i = 0; i < 8; i++) begin
      copi = 1'b1; sclk = 1'b1; #HALF;
      sclk = 1'b0; #HALF;
    end
    gap();
    check_all("sclk_ncs_hi", 40'h00_00_77_00_00);

    // reset released with nCS low mid-frame: whole following frame ignored
    ncs = 1'b0; #HALF;
    shift_bits(17'h00005, 3);
    #7 rst_n = 1'b0;
    #30 rst_n = 1'b1;
    #HALF;
    shift_bits(17'h084AB, 16);
    end_frame();
    check_all("rel_ncs_low", 40'h0);
    gap();
    send_frame(17'h084CD, 16);
    check_all("post_rel", 40'hCD_00_00_00_00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
